if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; legal values are powers of two from 2 to 8.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port imem_addr, output, 64, fetch address to instruction memory, equal to the fetch PC register.
REQ-006 SHALL have port imem_rdata, input, 32, instruction word for imem_addr.
REQ-007 SHALL have port imem_ready, input, 1; 1 means imem_rdata is valid this cycle.
REQ-008 SHALL have port redirect_valid, input, 1, taken branch from EX/MEM (branch AND zero).
REQ-009 SHALL have port redirect_pc, input, 64, branch target.
REQ-010 SHALL have port out_valid, output, 1; queue head is valid.
REQ-011 SHALL have port out_ready, input, 1; IF/ID accepts the head (0 = stall).
REQ-012 SHALL have port out_data, output, 96, {pc[63:0], instr[31:0]}, the IF/ID dataIn layout.
REQ-013 SHALL have port count, output, 4, current occupancy, 0..DEPTH.

Function
REQ-014 SHALL define push = imem_ready AND NOT redirect_valid AND (count<DEPTH OR pop).
REQ-015 SHALL define pop = out_valid AND out_ready.
REQ-016 SHALL, on push, write {pc, imem_rdata} at the tail and set pc <= pc + 4, with 64-bit wrap-around.
REQ-017 SHALL, on pop, advance the head.
REQ-018 SHALL, on simultaneous push and pop, leave count unchanged; this holds when full, giving one instruction per cycle.
REQ-019 SHALL drive out_valid = (count != 0) from registered state only, with no combinational path from imem_rdata to out_data.
REQ-020 SHALL drive out_data = 96'h0 whenever out_valid = 0.
REQ-021 SHALL hold the head stable while out_valid=1 and out_ready=0.
REQ-022 SHALL give redirect_valid priority over push and pop: next cycle count=0, pointers=0, pc=redirect_pc with bits [1:0] forced to 00.
REQ-023 SHALL treat a pop coincident with a redirect as a consumed wrong-path entry; it SHALL not re-appear.
REQ-024 SHALL have a latency of 1 cycle from the push edge to out_valid=1 for that entry.
REQ-025 SHALL, when imem_ready=0, leave pc unchanged and still permit pops.
REQ-026 SHALL, when full without pop, hold pc and ignore imem_rdata.
REQ-027 SHALL maintain wrap-around of head and tail modulo DEPTH, using pointers of log2(DEPTH) bits plus a separate count.

Reset
REQ-028 SHALL, asynchronously on rst_n=0, set pc=RESET_PC, count=0, head=tail=0, all entries=0, out_valid=0 and out_data=0.
REQ-029 SHALL discard in-flight queue contents on reset mid-operation, with no pop or push on that edge.
REQ-030 SHALL, on the first rising edge after rst_n rises with imem_ready=1, push the entry for RESET_PC.

Structure
REQ-031 SHALL take XLEN=64, ILEN=32, PC_STEP=4 and IFQ_W=96 from shared package cpu_pkg.
REQ-032 SHALL place the storage array, pointers and count in sub-module fetch_fifo, parameterised by width and DEPTH.
REQ-033 SHALL keep in if_if_fetch_queue the PC register, push/pop/redirect control and output zeroing.

Verification
REQ-034 SHALL verify reset and stream: RESET_PC=0, imem_ready=1, out_ready=1, words 0x00500093, 0x00a00113 -> out_data {0,0x00500093} then {4,0x00a00113} on consecutive cycles.
REQ-035 SHALL verify fill: out_ready=0 for 6 cycles -> count reaches 4 and stays; pc=0x10; head stays {0,..}; the release pops one per cycle with no gaps.
REQ-036 SHALL verify full plus simultaneous push/pop: count=4, out_ready=1 -> count stays 4, pc advances by 4 each cycle.
REQ-037 SHALL verify redirect: count=3, redirect_valid=1, redirect_pc=0x43 -> next cycle count=0, out_valid=0, imem_addr=0x40; then the first output is {0x40,..}.
REQ-038 SHALL verify memory wait: imem_ready=0 for 3 cycles with a nonempty queue -> pops continue, pc is frozen, and no duplicate entries appear.
REQ-039 SHALL verify asynchronous reset: rst_n low mid-cycle with count=2 -> out_valid=0 and imem_addr=RESET_PC immediately, before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID queue entry layout used by the fetch stage.
package cpu_pkg;

   localparam int XLEN    = 64;
   localparam int ILEN    = 32;
   localparam int PC_STEP = 4;
   localparam int IFQ_W   = XLEN + ILEN;
   localparam int CNT_W   = 4;

   // Field order matches the IF/ID dataIn layout {pc, instr}.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } ifq_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO for the fetch queue: storage, head/tail pointers and occupancy
// count. Flush empties it in one cycle; the caller guarantees no overflow or underflow.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int WIDTH = IFQ_W,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] cnt;

   // NOTE: the storage is reset along with the pointers so a freshly reset queue
   // reads as all-zero entries; state is updated with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            mem[tail] <= wdata;
            tail      <= tail + PTR_W'(1);
         end
         if (pop) head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
   assign rdata = mem[head];
   assign count = cnt;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, decides push/pop/redirect each
// cycle and presents the queue head to IF/ID as {pc, instr}.
module if_fetch_queue
   import cpu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 64'h0,
   parameter int              DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [XLEN-1:0]   imem_addr,
   input  logic [ILEN-1:0]   imem_rdata,
   input  logic              imem_ready,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IFQ_W-1:0]  out_data,
   output logic [CNT_W-1:0]  count
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [XLEN-1:0]  pc;
   logic [CNT_W-1:0] occ;
   logic             push;
   logic             pop;
   ifq_entry_t       wr_entry;
   ifq_entry_t       head_entry;

   assign out_valid = (occ != '0);
   assign pop       = out_valid & out_ready;
   // A pop frees a slot on the same edge, so a full queue still streams one per cycle.
   assign push      = imem_ready & ~redirect_valid & ((occ < DEPTH_C) | pop);

   assign wr_entry.pc    = pc;
   assign wr_entry.instr = imem_rdata;

   fetch_fifo #(
      .WIDTH (IFQ_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop & ~redirect_valid),
      .wdata (wr_entry),
      .rdata (head_entry),
      .count (occ)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              pc <= RESET_PC;
      else if (redirect_valid) pc <= align_pc(redirect_pc);
      else if (push)           pc <= pc + XLEN'(PC_STEP);
   end

   // NOTE: out_data is driven only from registered FIFO state, never from
   // imem_rdata, and is zeroed whenever the head is not valid.
   assign out_data  = out_valid ? head_entry : '0;
   assign imem_addr = pc;
   assign count     = occ;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model.
module tb_if_fetch_queue;
   import cpu_pkg::*;

   localparam logic [63:0] RESET_PC = 64'h0;
   localparam int          DEPTH    = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [63:0]       imem_addr;
   logic [31:0]       imem_rdata;
   logic              imem_ready;
   logic              redirect_valid;
   logic [63:0]       redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [95:0]       out_data;
   logic [3:0]        count;

   int                errors = 0;
   int                checks = 0;
   int                mdl_cnt;
   logic [63:0]       mdl_pc;
   logic [95:0]       exp_q[$];

   if_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_ready     (imem_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .count          (count)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: the two stream words at 0 and 4, a hash elsewhere.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'h0:   return 32'h0050_0093;
         64'h4:   return 32'h00a0_0113;
         default: return a[31:0] ^ a[63:32] ^ 32'h9e37_79b9;
      endcase
   endfunction

   assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hdead_beef;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mdl_cnt = 0;
      mdl_pc  = RESET_PC;
      exp_q.delete();
   endtask

   // Drive one cycle of inputs, wait for the edge, then apply the fetch rules to the model.
   task automatic step(input bit rdy, input bit ordy, input bit rv, input logic [63:0] rpc);
      bit mpop, mpush;
      imem_ready     = rdy;
      out_ready      = ordy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      mpop  = (mdl_cnt != 0) && ordy;
      mpush = rdy && !rv && ((mdl_cnt < DEPTH) || mpop);
      @(posedge clk);
      #1;
      if (rv) begin
         mdl_cnt = 0;
         mdl_pc  = {rpc[63:2], 2'b00};
         exp_q.delete();
      end else begin
         if (mpush) begin
            exp_q.push_back({mdl_pc, mem_word(mdl_pc)});
            mdl_pc = mdl_pc + 64'd4;
         end
         mdl_cnt = mdl_cnt + int'(mpush) - int'(mpop);
      end
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", 96'(out_valid), 96'(0));
      check("rst_imem_addr", 96'(imem_addr), 96'(RESET_PC));
      check("rst_count", 96'(count), 96'(0));
      check("rst_out_data", out_data, 96'(0));
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor: compares state each cycle and retires the expected head on every handshake.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("count", 96'(count), 96'(mdl_cnt));
         check("out_valid", 96'(out_valid), 96'(mdl_cnt != 0));
         check("imem_addr", 96'(imem_addr), 96'(mdl_pc));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_data: got %h expected no entry at %0t", out_data, $time);
            end else begin
               check("out_data", out_data, exp_q[0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end else begin
            check("out_data_zero", out_data, 96'(0));
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      imem_ready     = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      model_reset();
      #2;
      check("init_out_valid", 96'(out_valid), 96'(0));
      check("init_imem_addr", 96'(imem_addr), 96'(RESET_PC));
      check("init_count", 96'(count), 96'(0));
      check("init_out_data", out_data, 96'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Stream from reset: first edge pushes RESET_PC, outputs follow one per cycle.
      step(1, 1, 0, '0);
      check("stream0", out_data, {64'h0, 32'h0050_0093});
      step(1, 1, 0, '0);
      check("stream1", out_data, {64'h4, 32'h00a0_0113});
      async_reset();

      // Fill with the consumer stalled.
      for (int i = 0; i < 6; i++) step(1, 0, 0, '0);
      check("fill_count", 96'(count), 96'(4));
      check("fill_pc", 96'(imem_addr), 96'(64'h10));
      check("fill_head_pc", 96'(out_data[95:32]), 96'(0));

      // Full queue with simultaneous push and pop.
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, '0);
         check("full_count", 96'(count), 96'(4));
         check("full_pc", 96'(imem_addr), 96'(64'h10 + 64'(4 * (i + 1))));
      end

      // Redirect with three entries queued.
      step(0, 1, 0, '0);
      check("pre_redir_count", 96'(count), 96'(3));
      step(1, 1, 1, 64'h43);
      check("redir_count", 96'(count), 96'(0));
      check("redir_valid", 96'(out_valid), 96'(0));
      check("redir_pc", 96'(imem_addr), 96'(64'h40));
      step(1, 1, 0, '0);
      check("redir_head_pc", 96'(out_data[95:32]), 96'(64'h40));

      // Memory wait: pops continue, pc frozen.
      step(1, 0, 0, '0);
      step(1, 0, 0, '0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, '0);
         check("wait_pc", 96'(imem_addr), 96'(64'h4c));
         check("wait_count", 96'(count), 96'(2 - i));
      end

      // 64-bit pc wrap-around after a misaligned redirect near the top of memory.
      step(1, 1, 1, 64'hffff_ffff_ffff_fffa);
      check("wrap_redir_pc", 96'(imem_addr), 96'(64'hffff_ffff_ffff_fff8));
      step(1, 0, 0, '0);
      step(1, 0, 0, '0);
      check("wrap_pc", 96'(imem_addr), 96'(64'h0));
      step(1, 0, 0, '0);
      check("wrap_head_pc", 96'(out_data[95:32]), 96'(64'hffff_ffff_ffff_fff8));

      // Asynchronous reset with two entries in flight.
      step(0, 1, 0, '0);
      check("pre_reset_count", 96'(count), 96'(2));
      async_reset();

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 4) < 3),
              bit'($urandom_range(0, 19) == 0), {$urandom, $urandom});
      end
      step(0, 1, 0, '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
